// File: rtl/unified_memory_pl_if.sv
// rtl/unified_memory_pl_if.sv - data-port bundle for unified_memory_pl
// Master drives requests; slave returns ready, response strobe and read data.
interface unified_memory_pl_if;
  logic        req;
  logic        we;
  logic [3:0]  byte_en;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        ready;
  logic        resp_valid;
  logic [31:0] data_out;

  modport master (
    output req, we, byte_en, data_addr, data_in,
    input  ready, resp_valid, data_out
  );

  modport slave (
    input  req, we, byte_en, data_addr, data_in,
    output ready, resp_valid, data_out
  );
endinterface

// File: rtl/unified_memory_pl.sv
// rtl/unified_memory_pl.sv - unified instruction/data word memory with pipelined data reads
// Combinational instruction port, byte-enabled writes, fixed-latency reads, sticky first-error capture.
module unified_memory_pl #(
  parameter int ADDR_BITS    = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PC,
  output logic [31:0]          instruction,
  unified_memory_pl_if.slave   dp,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int IW    = ADDR_BITS - 2;
  localparam int DEPTH = 1 << IW;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q;
  logic           ready_q;
  logic           resp_valid_q;
  logic [31:0]    data_out_q;
  logic [IW-1:0]  raddr_q;
  logic           roor_q;
  logic [1:0]     cnt_q;
  logic           err_q;
  logic [1:0]     err_code_q;
  logic [31:0]    mem_q [DEPTH];

  logic           accept;
  logic           data_oor;
  logic           misaligned;
  logic           pc_oor;
  logic [IW-1:0]  didx;
  logic [IW-1:0]  pidx;
  logic [1:0]     err_d;
  logic           unused_pc;

  assign didx       = dp.data_addr[ADDR_BITS-1:2];
  assign pidx       = PC[ADDR_BITS-1:2];
  assign data_oor   = |dp.data_addr[31:ADDR_BITS];
  assign misaligned = |dp.data_addr[1:0];
  assign pc_oor     = |PC[31:ADDR_BITS];
  assign unused_pc  = ^PC[1:0];

  assign accept = dp.req && dp.ready;

  assign dp.ready      = ready_q && !reset;
  assign dp.resp_valid = resp_valid_q;
  assign dp.data_out   = data_out_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign instruction   = pc_oor ? 32'h0 : mem_q[pidx];

  // Same-cycle error priority: data out-of-range, then PC out-of-range, then misalignment.
  always_comb begin
    err_d = 2'b00;
    if (accept && data_oor) begin
      err_d = 2'b10;
    end else if (pc_oor) begin
      err_d = 2'b11;
    end else if (accept && misaligned) begin
      err_d = 2'b01;
    end
  end

  // Memory is deliberately outside reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (accept && dp.we && !data_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (dp.byte_en[b]) begin
          mem_q[didx][8*b +: 8] <= dp.data_in[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      data_out_q   <= 32'h0;
      cnt_q        <= 2'd0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      resp_valid_q <= 1'b0;
      if (!err_q && (err_d != 2'b00)) begin
        err_q      <= 1'b1;
        err_code_q <= err_d;
      end
      if (state_q == IDLE) begin
        if (accept) begin
          if (dp.we) begin
            resp_valid_q <= 1'b1;
          end else if (READ_LATENCY == 1) begin
            resp_valid_q <= 1'b1;
            data_out_q   <= data_oor ? 32'h0 : mem_q[didx];
          end else begin
            state_q <= BUSY;
            ready_q <= 1'b0;
            raddr_q <= didx;
            roor_q  <= data_oor;
            cnt_q   <= 2'(READ_LATENCY - 2);
          end
        end
      end else begin
        // No writes can land while busy, so reading at completion sees every earlier write.
        if (cnt_q == 2'd0) begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b1;
          data_out_q   <= roor_q ? 32'h0 : mem_q[raddr_q];
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_memory_pl.sv
// tb/tb_unified_memory_pl.sv - bench for unified_memory_pl
// Two instances (read latency 2 and 3) share stimulus; sel picks which one receives requests.
module tb_unified_memory_pl;

  localparam int AB = 14;

  logic        clk = 1'b0;
  logic        rst2, rst3;
  logic [31:0] pc;
  logic [31:0] instr2, instr3;
  logic        err2, err3;
  logic [1:0]  code2, code3;

  logic        sel;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, din;

  unified_memory_pl_if if2();
  unified_memory_pl_if if3();

  assign if2.req = req & ~sel;
  assign if3.req = req & sel;
  assign if2.we = we;        assign if3.we = we;
  assign if2.byte_en = be;   assign if3.byte_en = be;
  assign if2.data_addr = addr; assign if3.data_addr = addr;
  assign if2.data_in = din;  assign if3.data_in = din;

  logic        ready_s, resp_s, err_s;
  logic [31:0] dout_s;
  logic [1:0]  code_s;
  assign ready_s = sel ? if3.ready      : if2.ready;
  assign resp_s  = sel ? if3.resp_valid : if2.resp_valid;
  assign dout_s  = sel ? if3.data_out   : if2.data_out;
  assign err_s   = sel ? err3  : err2;
  assign code_s  = sel ? code3 : code2;

  unified_memory_pl #(.ADDR_BITS(AB), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst2), .PC(pc), .instruction(instr2), .dp(if2),
    .err(err2), .err_code(code2)
  );

  unified_memory_pl #(.ADDR_BITS(AB), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst3), .PC(pc), .instruction(instr3), .dp(if3),
    .err(err3), .err_code(code3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: word array per instance plus first-error bookkeeping.
  logic [31:0] mm [2][64];
  logic        exp_err [2];
  logic [1:0]  exp_code [2];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_err(input int s, input logic [1:0] c);
    if (!exp_err[s]) begin
      exp_err[s]  = 1'b1;
      exp_code[s] = c;
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready_s && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_ready"}, 32'(ready_s), 32'd1);
  endtask

  task automatic clear_model(input int s);
    exp_err[s]  = 1'b0;
    exp_code[s] = 2'b00;
    last_rd[s]  = 32'h0;
  endtask

  task automatic pulse_reset(input int s);
    if (s == 0) rst2 = 1'b1; else rst3 = 1'b1;
    tick();
    tick();
    if (s == 0) rst2 = 1'b0; else rst3 = 1'b0;
    clear_model(s);
    #1;
  endtask

  task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int          s;
    int          idx;
    int          lat;
    logic        oor;
    logic [31:0] exp;
    logic [31:0] mask;
    s   = sel ? 1 : 0;
    oor = (a >> AB) != 0;
    idx = int'(a[7:2]);
    wait_ready(tag);
    req = 1'b1; we = w; be = b; addr = a; din = d;
    tick();
    req = 1'b0;
    if (oor) note_err(s, 2'b10);
    else if (a[1:0] != 2'b00) note_err(s, 2'b01);
    if (w) begin
      if (!oor) begin
        for (int k = 0; k < 4; k++) begin
          mask = 32'hFF << (8 * k);
          if (b[k]) mm[s][idx] = (mm[s][idx] & ~mask) | (d & mask);
        end
      end
      chk({tag, "_wresp"}, 32'(resp_s), 32'd1);
    end else begin
      exp = oor ? 32'h0 : mm[s][idx];
      lat = 1;
      while (!resp_s && lat < 10) begin
        tick();
        lat++;
      end
      chk({tag, "_latency"}, 32'(lat), sel ? 32'd3 : 32'd2);
      last_rd[s] = exp;
    end
    chk({tag, "_dout"}, dout_s, last_rd[s]);
    chk({tag, "_err"}, 32'(err_s), 32'(exp_err[s]));
    chk({tag, "_code"}, 32'(code_s), 32'(exp_code[s]));
  endtask

  initial begin
    sel = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; din = 32'h0; pc = 32'h0;
    rst2 = 1'b1; rst3 = 1'b1;
    clear_model(0);
    clear_model(1);
    tick();
    tick();
    chk("rst_ready", 32'(if2.ready), 32'd0);
    chk("rst_resp", 32'(if2.resp_valid), 32'd0);
    chk("rst_dout", if2.data_out, 32'h0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_code", 32'(code2), 32'd0);
    rst2 = 1'b0; rst3 = 1'b0;
    #1;
    chk("post_rst_ready", 32'(if2.ready), 32'd1);

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 64; i++) access(1'b1, 4'hF, 32'(i * 4), $urandom, "fill");
    end
    sel = 1'b0;

    access(1'b1, 4'hF, 32'h10, 32'hAABBCCDD, "be_full");
    access(1'b1, 4'h5, 32'h10, 32'h11223344, "be_0101");
    access(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, "be_none");
    access(1'b0, 4'h0, 32'h10, 32'h0, "be_read");
    chk("be_value", if2.data_out, 32'hAA22CC44);

    wait_ready("b2b");
    req = 1'b1; we = 1'b0; addr = 32'h0;
    chk("b2b_rdy0", 32'(if2.ready), 32'd1);
    tick();
    addr = 32'h4;
    chk("b2b_rdy1", 32'(if2.ready), 32'd0);
    chk("b2b_resp1", 32'(if2.resp_valid), 32'd0);
    tick();
    chk("b2b_rdy2", 32'(if2.ready), 32'd1);
    chk("b2b_resp2", 32'(if2.resp_valid), 32'd1);
    chk("b2b_data0", if2.data_out, mm[0][0]);
    tick();
    req = 1'b0;
    chk("b2b_rdy3", 32'(if2.ready), 32'd0);
    tick();
    chk("b2b_rdy4", 32'(if2.ready), 32'd1);
    chk("b2b_resp4", 32'(if2.resp_valid), 32'd1);
    chk("b2b_data1", if2.data_out, mm[0][1]);
    last_rd[0] = mm[0][1];

    access(1'b1, 4'hF, 32'h20, 32'h8C010004, "imem_wr");
    pc = 32'h20;
    #1;
    chk("imem_fetch", instr2, 32'h8C010004);
    pc = 32'h00010000;
    #1;
    chk("imem_oor", instr2, 32'h0);
    tick();
    pc = 32'h0;
    note_err(0, 2'b11);
    note_err(1, 2'b11);
    chk("pc_oor_err", 32'(err2), 32'd1);
    chk("pc_oor_code", 32'(code2), 32'(exp_code[0]));

    pulse_reset(0);
    access(1'b0, 4'h0, 32'h20, 32'h0, "mem_kept");

    access(1'b1, 4'hF, 32'h00004000, 32'hDEADBEEF, "oor_wr");
    access(1'b0, 4'h0, 32'h0, 32'h0, "oor_nochg");
    access(1'b0, 4'h0, 32'h00004000, 32'h0, "oor_rd");
    access(1'b0, 4'h0, 32'h13, 32'h0, "oor_then_mis");
    chk("oor_sticky", 32'(code2), 32'd2);

    pulse_reset(0);
    access(1'b1, 4'hF, 32'h10, 32'h55, "mis_wr");
    access(1'b0, 4'h0, 32'h13, 32'h0, "mis_rd");
    chk("mis_value", if2.data_out, 32'h55);
    chk("mis_code", 32'(code2), 32'd1);

    sel = 1'b1;
    wait_ready("rstrd");
    req = 1'b1; we = 1'b0; addr = 32'h40;
    tick();
    rst3 = 1'b1;
    we = 1'b1; be = 4'hF; addr = 32'h44; din = 32'hFFFFFFFF;
    #1;
    chk("rstrd_rdy_in", 32'(if3.ready), 32'd0);
    tick();
    chk("rstrd_resp", 32'(if3.resp_valid), 32'd0);
    chk("rstrd_dout", if3.data_out, 32'h0);
    chk("rstrd_rdy_hold", 32'(if3.ready), 32'd0);
    rst3 = 1'b0; req = 1'b0;
    clear_model(1);
    #1;
    chk("rstrd_rdy_after", 32'(if3.ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstrd_no_resp", 32'(if3.resp_valid), 32'd0);
    end
    access(1'b0, 4'h0, 32'h40, 32'h0, "rstrd_w40");
    access(1'b0, 4'h0, 32'h44, 32'h0, "rstrd_w44");

    sel = 1'b0;
    pulse_reset(0);
    for (int i = 0; i < 60; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'h1 << $urandom_range(AB, 31));
      access(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
